// File: rtl/usb_capture_reader_pkg.sv
// Shared definitions for the USB capture reader: default sizes and FSM state encoding.
package usb_capture_reader_pkg;

   localparam int unsigned DW_DEF         = 11;
   localparam int unsigned DEPTH_LOG2_DEF = 10;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_CAPTURE = 2'd1;
   localparam state_t ST_DRAIN   = 2'd2;
   localparam state_t ST_FLUSH   = 2'd3;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port, no reset,
// so synthesis can map it onto block RAM.
module capture_ram
   import usb_capture_reader_pkg::*;
#(
   parameter int unsigned AW = DEPTH_LOG2_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(1 << AW) - 1];
   logic [DW-1:0] r_rdata;

   // Write port and registered read port; read data only changes on an issued read.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/usb_capture_reader.sv
// Captures one buffer of ADC samples, then drains it towards the USB packing stage,
// throttled by the USB FIFO full flag. Control, pointers and output registers live here.
module usb_capture_reader
   import usb_capture_reader_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int unsigned DW         = DW_DEF
) (
   input  logic          rdclk,
   input  logic          reset,
   input  logic [DW-1:0] din,
   input  logic          din_valid,
   input  logic          arm,
   input  logic          abort,
   input  logic          usb_full,
   output logic [DW-1:0] data_out,
   output logic          data_valid,
   output logic          busy,
   output logic          capture_done
);

   localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
   logic                  w_wr_en;
   logic                  w_rd_en;
   logic                  w_last_rd;
   logic [DW-1:0]         w_ram_q;
   logic [DW-1:0]         r_data_hold;
   logic                  r_data_valid;
   logic                  r_busy;
   logic                  r_capture_done;

   // A read issued in the abort cycle is still allowed to complete.
   assign w_wr_en   = (r_state == ST_CAPTURE) && din_valid;
   assign w_rd_en   = (r_state == ST_DRAIN) && !usb_full;
   assign w_last_rd = w_rd_en && (r_rd_ptr == LAST_ADDR);

   capture_ram #(
      .AW (DEPTH_LOG2),
      .DW (DW)
   ) u_capture_ram (
      .i_clk   (rdclk),
      .i_we    (w_wr_en),
      .i_waddr (r_wr_ptr),
      .i_wdata (din),
      .i_re    (w_rd_en),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_ram_q)
   );

   // Next-state and pointer update; abort overrides every state including IDLE+arm.
   always_comb begin
      w_state_nxt  = r_state;
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      if (abort) begin
         w_state_nxt  = ST_IDLE;
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (arm) begin
                  w_state_nxt  = ST_CAPTURE;
                  w_wr_ptr_nxt = '0;
               end
            end
            ST_CAPTURE: begin
               if (w_wr_en) begin
                  if (r_wr_ptr == LAST_ADDR) begin
                     // Write pointer parks at the last address instead of wrapping.
                     w_state_nxt  = ST_DRAIN;
                     w_rd_ptr_nxt = '0;
                  end else begin
                     w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_rd_en) begin
                  if (r_rd_ptr == LAST_ADDR) begin
                     w_state_nxt = ST_FLUSH;
                  end else begin
                     w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
                  end
               end
            end
            ST_FLUSH: begin
               w_state_nxt  = ST_IDLE;
               w_wr_ptr_nxt = '0;
               w_rd_ptr_nxt = '0;
            end
            default: begin
               w_state_nxt  = ST_IDLE;
               w_wr_ptr_nxt = '0;
               w_rd_ptr_nxt = '0;
            end
         endcase
      end
   end

   // State, pointers and output flags.
   always_ff @(posedge rdclk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_data_valid   <= 1'b0;
         r_busy         <= 1'b0;
         r_capture_done <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_wr_ptr       <= w_wr_ptr_nxt;
         r_rd_ptr       <= w_rd_ptr_nxt;
         r_data_valid   <= w_rd_en;
         r_busy         <= (w_state_nxt != ST_IDLE);
         r_capture_done <= w_last_rd && !abort;
      end
   end

   // Keeps the last presented sample so data_out holds while data_valid is low.
   always_ff @(posedge rdclk or posedge reset) begin
      if (reset) begin
         r_data_hold <= '0;
      end else if (r_data_valid) begin
         r_data_hold <= w_ram_q;
      end
   end

   // The RAM read register supplies the fresh sample; the hold register covers idle cycles
   // and gives a clean zero after reset even though the RAM itself is not reset.
   assign data_out     = r_data_valid ? w_ram_q : r_data_hold;
   assign data_valid   = r_data_valid;
   assign busy         = r_busy;
   assign capture_done = r_capture_done;

endmodule

// File: tb/tb_usb_capture_reader.sv
// Scoreboard bench for usb_capture_reader with a 16-entry buffer.
module tb_usb_capture_reader;

   localparam int DL2   = 4;
   localparam int DEPTH = 16;
   localparam int W     = 11;

   logic         rdclk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic         arm = 1'b0;
   logic         abort = 1'b0;
   logic         usb_full = 1'b0;
   logic [W-1:0] data_out;
   logic         data_valid;
   logic         busy;
   logic         capture_done;

   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned pulse_cyc[$];
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [W-1:0] last_out = '0;
   exp_t        mon_e;

   usb_capture_reader #(
      .DEPTH_LOG2 (DL2),
      .DW         (W)
   ) dut (
      .rdclk        (rdclk),
      .reset        (reset),
      .din          (din),
      .din_valid    (din_valid),
      .arm          (arm),
      .abort        (abort),
      .usb_full     (usb_full),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .busy         (busy),
      .capture_done (capture_done)
   );

   always #5 rdclk = ~rdclk;

   always @(posedge rdclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every output cycle is checked against the scoreboard.
   always @(negedge rdclk) begin
      if (reset) begin
         last_out = '0;
      end else if (data_valid) begin
         pulse_cyc.push_back(cyc);
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid: got data_valid=1 data_out=%0h, expected no pulse",
                     data_out);
         end else begin
            mon_e = sb_q.pop_front();
            check("data_out", 32'(data_out), 32'(mon_e.data));
            check("capture_done", 32'(capture_done), 32'(mon_e.last));
            last_out = mon_e.data;
         end
      end else begin
         check("done_without_valid", 32'(capture_done), 32'd0);
         check("data_out_hold", 32'(data_out), 32'(last_out));
      end
   end

   // din_mode: 0 back-to-back ramp, 1 every other cycle, 2 random with arm noise.
   // drain_mode: 0 no stall, 1 stall 3 cycles after 5th read, 2 random stalls with arm
   // noise, 3 abort after 7 reads.
   task automatic do_capture(input int din_mode, input int drain_mode);
      int   writes;
      int   reads;
      int   stall;
      int   it;
      exp_t e;
      pulse_cyc.delete();
      @(posedge rdclk); #1;
      arm = 1'b1;
      writes = 0;
      it = 0;
      while (writes < DEPTH) begin
         @(posedge rdclk); #1;
         arm = (din_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
         case (din_mode)
            0:       din_valid = 1'b1;
            1:       din_valid = (it % 2 == 0);
            default: din_valid = ($urandom_range(0, 2) != 0) || (it > 100);
         endcase
         if (din_valid) begin
            din = (din_mode == 0) ? W'(writes) : W'($urandom);
            e.data = din;
            e.last = (writes == DEPTH - 1);
            sb_q.push_back(e);
            writes++;
         end else begin
            din = W'($urandom);
         end
         it++;
      end
      reads = 0;
      stall = 0;
      it = 0;
      while (reads < DEPTH) begin
         @(posedge rdclk); #1;
         din_valid = 1'b0;
         arm = (drain_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
         case (drain_mode)
            1: begin
               usb_full = (reads == 5) && (stall < 3);
               if (usb_full) stall++;
            end
            2:       usb_full = ($urandom_range(0, 2) == 0) && (it < 200);
            default: usb_full = 1'b0;
         endcase
         it++;
         if (drain_mode == 3 && reads == 7) begin
            // This cycle's read still completes; everything after it is discarded.
            abort = 1'b1;
            usb_full = 1'b0;
            @(negedge rdclk); #1;
            while (sb_q.size() > 1) void'(sb_q.pop_back());
            if (sb_q.size() == 1) begin
               e = sb_q.pop_front();
               e.last = 1'b0;
               sb_q.push_back(e);
            end
            @(posedge rdclk); #1;
            abort = 1'b0;
            @(negedge rdclk);
            check("busy_after_abort", 32'(busy), 32'd0);
            repeat (3) @(negedge rdclk);
            check("abort_queue_empty", sb_q.size(), 32'd0);
            check("abort_pulse_count", pulse_cyc.size(), 32'd8);
            return;
         end
         if (!usb_full) reads++;
      end
      @(posedge rdclk); #1;
      usb_full = 1'b0;
      arm = 1'b0;
      @(negedge rdclk);
      check("busy_in_flush", 32'(busy), 32'd1);
      @(negedge rdclk);
      check("busy_after_flush", 32'(busy), 32'd0);
      check("queue_empty", sb_q.size(), 32'd0);
      check("pulse_count", pulse_cyc.size(), 32'(DEPTH));
      if (pulse_cyc.size() == DEPTH) begin
         if (drain_mode == 0) begin
            check("burst_span", pulse_cyc[DEPTH-1] - pulse_cyc[0], 32'(DEPTH - 1));
         end
         if (drain_mode == 1) begin
            check("stall_gap", pulse_cyc[5] - pulse_cyc[4], 32'd4);
            check("stall_span", pulse_cyc[DEPTH-1] - pulse_cyc[0], 32'(DEPTH - 1 + 3));
         end
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_data_out"}, 32'(data_out), 32'd0);
      check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_capture_done"}, 32'(capture_done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge rdclk);
      check_outputs_zero("reset");
      @(posedge rdclk); #3;
      reset = 1'b0;

      do_capture(0, 0);
      do_capture(1, 0);
      do_capture(2, 1);
      do_capture(2, 3);
      do_capture(1, 0);
      repeat (3) do_capture(2, 2);

      // Asynchronous reset in the middle of a capture, between clock edges.
      @(posedge rdclk); #1;
      arm = 1'b1;
      @(posedge rdclk); #1;
      arm = 1'b0;
      din_valid = 1'b1;
      repeat (5) begin
         @(posedge rdclk); #1;
         din = W'($urandom);
      end
      @(negedge rdclk);
      check("busy_mid_capture", 32'(busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_outputs_zero("async_reset");
      din_valid = 1'b0;
      sb_q.delete();
      @(posedge rdclk);
      @(posedge rdclk); #3;
      reset = 1'b0;
      repeat (4) @(negedge rdclk);
      check("idle_after_reset", 32'(busy), 32'd0);

      // arm and abort together in IDLE: abort wins.
      @(posedge rdclk); #1;
      arm = 1'b1;
      abort = 1'b1;
      @(posedge rdclk); #1;
      arm = 1'b0;
      abort = 1'b0;
      @(negedge rdclk);
      check("arm_abort_busy0", 32'(busy), 32'd0);
      @(negedge rdclk);
      check("arm_abort_busy1", 32'(busy), 32'd0);

      do_capture(0, 0);
      repeat (3) @(negedge rdclk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
